fp_unit_sched: RTL and testbench

//  Parametrised issue/retire scheduler for the FP cluster. One request stream is dispatched to NUM_UNITS

---
 rtl/fp_unit_sched_pkg.sv | 25 ++
 rtl/fp_unit_sched_if.sv | 45 ++++
 rtl/fp_unit_sched_rob.sv | 89 ++++++++
 rtl/fp_unit_sched.sv | 91 +++++++++
 tb/tb_fp_unit_sched.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_unit_sched_pkg.sv
// rtl/fp_unit_sched_pkg.sv - shared types and constants for the FP issue/retire scheduler
package fp_unit_sched_pkg;

  localparam int FP_UNIT_W = 2;
  localparam int FP_IDX_W  = 3;
  localparam int FP_DATA_W = 64;
  localparam int FP_FLAG_W = 5;

  // fflags are {NV,DZ,OF,UF,NX}; an op sent to a non-existent unit retires as invalid-operation
  localparam logic [FP_FLAG_W-1:0] FP_FLAG_NV = 5'b10000;

  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic [FP_UNIT_W-1:0] unit;
    logic [FP_DATA_W-1:0] data;
    logic [FP_FLAG_W-1:0] flags;
  } fp_sched_entry_t;

  typedef struct packed {
    logic                epoch;
    logic [FP_IDX_W-1:0] idx;
  } fp_sched_tag_t;

endpackage

// File: rtl/fp_unit_sched_if.sv
// rtl/fp_unit_sched_if.sv - request, issue, completion and response bundle of the FP scheduler
interface fp_unit_sched_if #(
  parameter int NUM_UNITS = 4,
  parameter int UNIT_W    = 2,
  parameter int IDX_W     = 3,
  parameter int PAYLOAD_W = 200,
  parameter int DATA_W    = 64,
  parameter int FLAG_W    = 5
) ();

  logic                           req_valid;
  logic                           req_ready;
  logic [UNIT_W-1:0]              req_unit;
  logic [PAYLOAD_W-1:0]           req_payload;
  logic [NUM_UNITS-1:0]           iss_valid;
  logic [NUM_UNITS-1:0]           iss_ready;
  logic [PAYLOAD_W-1:0]           iss_payload;
  logic [IDX_W:0]                 iss_tag;
  logic [NUM_UNITS-1:0]           cmp_valid;
  logic [NUM_UNITS*(IDX_W+1)-1:0] cmp_tag;
  logic [NUM_UNITS*DATA_W-1:0]    cmp_data;
  logic [NUM_UNITS*FLAG_W-1:0]    cmp_flags;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [DATA_W-1:0]              rsp_data;
  logic [FLAG_W-1:0]              rsp_flags;
  logic [UNIT_W-1:0]              rsp_unit;
  logic [IDX_W:0]                 occupancy;
  logic                           proto_err;

  modport master (
    output req_valid, req_unit, req_payload, iss_ready,
    output cmp_valid, cmp_tag, cmp_data, cmp_flags, rsp_ready,
    input  req_ready, iss_valid, iss_payload, iss_tag,
    input  rsp_valid, rsp_data, rsp_flags, rsp_unit, occupancy, proto_err
  );

  modport slave (
    input  req_valid, req_unit, req_payload, iss_ready,
    input  cmp_valid, cmp_tag, cmp_data, cmp_flags, rsp_ready,
    output req_ready, iss_valid, iss_payload, iss_tag,
    output rsp_valid, rsp_data, rsp_flags, rsp_unit, occupancy, proto_err
  );

endinterface

// File: rtl/fp_unit_sched_rob.sv
// rtl/fp_unit_sched_rob.sv - tag-indexed reorder buffer with multi-port completion and epoch flush
module fp_unit_sched_rob
  import fp_unit_sched_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int ROB_DEPTH = 8,
  parameter int IDX_W     = FP_IDX_W,
  parameter int DATA_W    = FP_DATA_W,
  parameter int FLAG_W    = FP_FLAG_W
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           alloc,
  input  logic                           alloc_illegal,
  input  logic [FP_UNIT_W-1:0]           alloc_unit,
  input  logic                           retire,
  input  logic [NUM_UNITS-1:0]           cmp_valid,
  input  logic [NUM_UNITS*(IDX_W+1)-1:0] cmp_tag,
  input  logic [NUM_UNITS*DATA_W-1:0]    cmp_data,
  input  logic [NUM_UNITS*FLAG_W-1:0]    cmp_flags,
  output fp_sched_entry_t                head_entry,
  output logic [IDX_W-1:0]               tail,
  output logic                           epoch,
  output logic [IDX_W:0]                 occupancy,
  output logic                           full,
  output logic                           proto_err
);

  fp_sched_entry_t   entries [ROB_DEPTH];
  logic [IDX_W-1:0]  head;

  logic [NUM_UNITS-1:0] cmp_epoch;
  logic [IDX_W-1:0]     cmp_idx   [NUM_UNITS];
  logic [DATA_W-1:0]    cmp_d     [NUM_UNITS];
  logic [FLAG_W-1:0]    cmp_f     [NUM_UNITS];

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_cmp
    assign cmp_epoch[u] = cmp_tag[u*(IDX_W+1)+IDX_W];
    assign cmp_idx[u]   = cmp_tag[u*(IDX_W+1) +: IDX_W];
    assign cmp_d[u]     = cmp_data[u*DATA_W +: DATA_W];
    assign cmp_f[u]     = cmp_flags[u*FLAG_W +: FLAG_W];
  end

  assign head_entry = entries[head];
  assign full       = occupancy == (IDX_W+1)'(ROB_DEPTH);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      epoch     <= reset ? 1'b0 : ~epoch;
      if (reset) proto_err <= 1'b0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].done  <= 1'b0;
      end
    end else begin
      // Old-epoch completions are units draining ops from before a flush: drop them quietly.
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (cmp_valid[u] && cmp_epoch[u] == epoch) begin
          if (entries[cmp_idx[u]].valid && !entries[cmp_idx[u]].done) begin
            entries[cmp_idx[u]].done  <= 1'b1;
            entries[cmp_idx[u]].data  <= cmp_d[u];
            entries[cmp_idx[u]].flags <= cmp_f[u];
          end else begin
            proto_err <= 1'b1;
          end
        end
      end
      if (retire) begin
        entries[head].valid <= 1'b0;
        head                <= head + 1'b1;
      end
      if (alloc) begin
        entries[tail] <= '{valid: 1'b1, done: alloc_illegal, unit: alloc_unit, data: '0,
                           flags: (alloc_illegal ? FP_FLAG_NV : '0)};
        tail          <= tail + 1'b1;
      end
      case ({alloc, retire})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/fp_unit_sched.sv
// rtl/fp_unit_sched.sv - FP cluster issue/retire scheduler: dispatch decode and in-order response
module fp_unit_sched
  import fp_unit_sched_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int UNIT_W    = FP_UNIT_W,
  parameter int ROB_DEPTH = 8,
  parameter int IDX_W     = FP_IDX_W,
  parameter int PAYLOAD_W = 200,
  parameter int DATA_W    = FP_DATA_W,
  parameter int FLAG_W    = FP_FLAG_W
) (
  input logic           clock,
  input logic           reset,
  input logic           clear,
  fp_unit_sched_if.slave bus
);

  logic [UNIT_W-1:0]    req_unit;
  logic [PAYLOAD_W-1:0] payload;
  logic                 illegal;
  logic                 unit_ready;
  logic                 req_ready;
  logic                 accept;
  logic                 retire;
  logic [NUM_UNITS-1:0] iss_valid;
  fp_sched_entry_t      head_entry;
  fp_sched_tag_t        iss_tag;
  logic [IDX_W-1:0]     tail;
  logic                 epoch;
  logic                 full;

  assign req_unit = bus.req_unit;
  assign payload  = bus.req_payload;
  assign illegal  = 32'(req_unit) >= NUM_UNITS;

  always_comb begin
    unit_ready = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++)
      if (32'(req_unit) == u) unit_ready = bus.iss_ready[u];
  end

  // Full uses registered occupancy, so a same-cycle retire cannot make room for this request.
  assign req_ready = !full && !clear && (illegal || unit_ready);
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    iss_valid = '0;
    for (int u = 0; u < NUM_UNITS; u++)
      iss_valid[u] = accept && !illegal && 32'(req_unit) == u;
  end

  assign iss_tag = '{epoch: epoch, idx: tail};
  assign retire  = bus.rsp_valid && bus.rsp_ready;

  fp_unit_sched_rob #(
    .NUM_UNITS (NUM_UNITS),
    .ROB_DEPTH (ROB_DEPTH),
    .IDX_W     (IDX_W),
    .DATA_W    (DATA_W),
    .FLAG_W    (FLAG_W)
  ) u_rob (
    .clock         (clock),
    .reset         (reset),
    .clear         (clear),
    .alloc         (accept),
    .alloc_illegal (illegal),
    .alloc_unit    (req_unit),
    .retire        (retire),
    .cmp_valid     (bus.cmp_valid),
    .cmp_tag       (bus.cmp_tag),
    .cmp_data      (bus.cmp_data),
    .cmp_flags     (bus.cmp_flags),
    .head_entry    (head_entry),
    .tail          (tail),
    .epoch         (epoch),
    .occupancy     (bus.occupancy),
    .full          (full),
    .proto_err     (bus.proto_err)
  );

  assign bus.req_ready   = req_ready;
  assign bus.iss_valid   = iss_valid;
  assign bus.iss_payload = payload;
  assign bus.iss_tag     = iss_tag;
  assign bus.rsp_valid   = head_entry.valid && head_entry.done;
  assign bus.rsp_data    = head_entry.data;
  assign bus.rsp_flags   = head_entry.flags;
  assign bus.rsp_unit    = head_entry.unit;

endmodule

// File: tb/tb_fp_unit_sched.sv
// tb/tb_fp_unit_sched.sv - scoreboard bench for fp_unit_sched with three units
module tb_fp_unit_sched;

  localparam int NU = 3;
  localparam int UW = 2;
  localparam int RD = 8;
  localparam int IW = 3;
  localparam int PW = 200;
  localparam int DW = 64;
  localparam int FW = 5;

  logic clock = 1'b0;
  logic reset;
  logic clear;

  always #5 clock = ~clock;

  fp_unit_sched_if #(.NUM_UNITS(NU), .UNIT_W(UW), .IDX_W(IW), .PAYLOAD_W(PW),
                     .DATA_W(DW), .FLAG_W(FW)) bus ();

  fp_unit_sched #(.NUM_UNITS(NU), .UNIT_W(UW), .ROB_DEPTH(RD), .IDX_W(IW),
                  .PAYLOAD_W(PW), .DATA_W(DW), .FLAG_W(FW)) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [FW-1:0] f;
    logic [UW-1:0] u;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got data %0h expected no response", bus.rsp_data);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_data",  64'(bus.rsp_data),  64'(mon_e.d));
        check("rsp_flags", 64'(bus.rsp_flags), 64'(mon_e.f));
        check("rsp_unit",  64'(bus.rsp_unit),  64'(mon_e.u));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [UW-1:0] u, input logic [IW:0] tag, input logic [DW-1:0] d,
                       input logic [FW-1:0] f, input bit push);
    logic [NU-1:0] ev;
    ev = '0;
    if (32'(u) < NU) ev[u] = 1'b1;
    bus.req_valid   = 1'b1;
    bus.req_unit    = u;
    bus.req_payload = PW'(d);
    #1;
    check("req_ready", 64'(bus.req_ready), 64'(1));
    check("iss_valid", 64'(bus.iss_valid), 64'(ev));
    if (32'(u) < NU) begin
      check("iss_tag",     64'(bus.iss_tag),     64'(tag));
      check("iss_payload", 64'(bus.iss_payload), d);
    end
    if (push) begin
      if (32'(u) < NU) sb.push_back('{d: d, f: f, u: u});
      else             sb.push_back('{d: '0, f: 5'b10000, u: u});
    end
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic set_cmp(input int lane, input logic [IW:0] tag, input logic [DW-1:0] d,
                         input logic [FW-1:0] f);
    bus.cmp_valid[lane]               = 1'b1;
    bus.cmp_tag[lane*(IW+1) +: IW+1]  = tag;
    bus.cmp_data[lane*DW +: DW]       = d;
    bus.cmp_flags[lane*FW +: FW]      = f;
  endtask

  task automatic cmp1(input int lane, input logic [IW:0] tag, input logic [DW-1:0] d,
                      input logic [FW-1:0] f);
    set_cmp(lane, tag, d, f);
    tick();
    bus.cmp_valid = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (sb.size() != 0 || bus.rsp_valid); k++) tick();
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    clear           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_unit    = '0;
    bus.req_payload = '0;
    bus.iss_ready   = '1;
    bus.cmp_valid   = '0;
    bus.cmp_tag     = '0;
    bus.cmp_data    = '0;
    bus.cmp_flags   = '0;
    bus.rsp_ready   = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    check("reset_occupancy", 64'(bus.occupancy), 64'(0));
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("reset_proto_err", 64'(bus.proto_err), 64'(0));
    check("reset_iss_valid", 64'(bus.iss_valid), 64'(0));
    check("reset_req_ready", 64'(bus.req_ready), 64'(1));

    // out-of-order completion, in-order retire
    bus.rsp_ready = 1'b1;
    issue(2'd0, 4'h0, 64'hA0A0, 5'h00, 1);
    issue(2'd1, 4'h1, 64'hB1B1, 5'h01, 1);
    cmp1(1, 4'h1, 64'hB1B1, 5'h01);
    check("head_not_done", 64'(bus.rsp_valid), 64'(0));
    tick();
    tick();
    set_cmp(0, 4'h0, 64'hA0A0, 5'h00);
    #1;
    check("no_bypass", 64'(bus.rsp_valid), 64'(0));
    @(posedge clock);
    #1;
    bus.cmp_valid = '0;
    check("a_rsp_next_cycle", 64'(bus.rsp_valid), 64'(1));
    check("a_rsp_data", 64'(bus.rsp_data), 64'hA0A0);
    drain();

    // fill to full with the consumer stalled
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      issue((i % 2 == 1) ? 2'd2 : 2'd0, {1'b0, 3'(2 + i)}, 64'(64'h100 + i), 5'(i), 1);
    bus.req_valid = 1'b1;
    bus.req_unit  = 2'd0;
    #1;
    check("full_req_ready", 64'(bus.req_ready), 64'(0));
    check("full_occupancy", 64'(bus.occupancy), 64'(8));
    set_cmp(0, 4'h2, 64'h100, 5'd0);
    set_cmp(2, 4'h3, 64'h101, 5'd1);
    tick();
    bus.cmp_valid = '0;
    check("head_done_valid", 64'(bus.rsp_valid), 64'(1));
    tick();
    check("held_rsp_data", 64'(bus.rsp_data), 64'h100);
    bus.rsp_ready = 1'b1;
    #1;
    check("retire_cycle_still_full", 64'(bus.req_ready), 64'(0));
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    check("slot_freed_req_ready", 64'(bus.req_ready), 64'(1));
    check("slot_freed_occupancy", 64'(bus.occupancy), 64'(7));
    issue(2'd0, 4'h2, 64'h108, 5'd0, 1);
    bus.rsp_ready = 1'b1;
    for (int i = 2; i < 8; i++)
      cmp1((i % 2 == 1) ? 2 : 0, {1'b0, 3'(2 + i)}, 64'(64'h100 + i), 5'(i));
    cmp1(0, 4'h2, 64'h108, 5'd0);
    drain();

    // busy divider blocks only its own unit
    bus.iss_ready = 3'b101;
    bus.req_valid = 1'b1;
    bus.req_unit  = 2'd1;
    #1;
    check("busy_req_ready", 64'(bus.req_ready), 64'(0));
    check("busy_iss_valid", 64'(bus.iss_valid), 64'(0));
    issue(2'd0, 4'h3, 64'h300, 5'd0, 1);
    bus.iss_ready = '1;
    cmp1(0, 4'h3, 64'h300, 5'd0);
    drain();

    // unit index beyond NUM_UNITS
    issue(2'd3, 4'h4, 64'hFFFF, 5'd0, 1);
    drain();

    // reset, then flush with stale completions
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_occupancy", 64'(bus.occupancy), 64'(0));
    issue(2'd0, 4'h0, 64'h400, 5'd0, 0);
    issue(2'd1, 4'h1, 64'h401, 5'd0, 0);
    issue(2'd2, 4'h2, 64'h402, 5'd0, 0);
    clear         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_unit  = 2'd0;
    #1;
    check("clear_req_ready", 64'(bus.req_ready), 64'(0));
    tick();
    clear         = 1'b0;
    bus.req_valid = 1'b0;
    check("clear_occupancy", 64'(bus.occupancy), 64'(0));
    check("clear_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    issue(2'd0, 4'h8, 64'h500, 5'd2, 1);
    cmp1(1, 4'h1, 64'hDEAD, 5'h1F);
    cmp1(2, 4'h0, 64'hBEEF, 5'h1F);
    check("stale_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("stale_proto_err", 64'(bus.proto_err), 64'(0));
    cmp1(0, 4'h8, 64'h500, 5'd2);
    drain();

    // duplicate completion
    bus.rsp_ready = 1'b0;
    issue(2'd1, 4'h9, 64'h600, 5'd3, 1);
    cmp1(1, 4'h9, 64'h600, 5'd3);
    check("first_cmp_proto_err", 64'(bus.proto_err), 64'(0));
    cmp1(1, 4'h9, 64'h666, 5'd7);
    check("dup_proto_err", 64'(bus.proto_err), 64'(1));
    tick();
    bus.rsp_ready = 1'b1;
    drain();
    check("proto_err_sticky", 64'(bus.proto_err), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("proto_err_reset", 64'(bus.proto_err), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
